// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: segment indices, FSM state types and hazard causes for pipe_stage_ctrl.
// Contents:
//   SEG_IF_ID..SEG_MEM_WB  bit positions of the four segment registers in seg_stall/seg_refresh
//   fetch_state_e          F_IDLE, F_WAIT, F_DISCARD
//   data_state_e           D_IDLE, D_WAIT
//   cause_e                winning hazard cause of the current cycle
//   seg_bit()              one-hot mask of a segment index
package pipe_ctrl_pkg;
    localparam int SEG_IF_ID  = 0;
    localparam int SEG_ID_EX  = 1;
    localparam int SEG_EX_MEM = 2;
    localparam int SEG_MEM_WB = 3;
    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DISCARD} fetch_state_e;
    typedef enum logic [1:0] {D_IDLE, D_WAIT} data_state_e;
    typedef enum logic [2:0] {C_NONE, C_FLUSH, C_DSTALL, C_DIV, C_LU, C_ISTALL} cause_e;
    function automatic logic [3:0] seg_bit(input int i);
        return 4'b0001 << i;
    endfunction
endpackage

// File: rtl/pipe_bus_track.sv
// pipe_bus_track: tracks one outstanding SRAM-like transaction and reports when it stalls the pipe.
// Parameter: DISCARD_EN  when set, a flush kills the outstanding fetch and the reply is dropped (F_DISCARD)
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_i                request presented
//   addr_ok_i            bus accepted the request
//   data_ok_i            bus returned data / ack
//   flush_i              pipeline flush (only honoured with DISCARD_EN)
//   state_o              current state (fetch_state_e encoding; D_IDLE/D_WAIT share F_IDLE/F_WAIT codes)
//   stall_o              transaction is holding up its stage
module pipe_bus_track
    import pipe_ctrl_pkg::*;
#(
    parameter bit DISCARD_EN = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_i,
    input  logic       addr_ok_i,
    input  logic       data_ok_i,
    input  logic       flush_i,
    output logic [1:0] state_o,
    output logic       stall_o
);
    fetch_state_e state_q, state_d;
    logic kill;
    always_comb begin
        kill = DISCARD_EN && flush_i;
        state_d = state_q;
        case (state_q)
            F_IDLE:    if (req_i && addr_ok_i) state_d = kill ? F_DISCARD : F_WAIT;
            F_WAIT:    state_d = data_ok_i ? F_IDLE : kill ? F_DISCARD : F_WAIT;
            F_DISCARD: if (data_ok_i) state_d = F_IDLE;
            default:   state_d = F_IDLE;
        endcase
        stall_o = (state_q == F_IDLE && req_i && !addr_ok_i) || (state_q == F_WAIT && !data_ok_i) || state_q == F_DISCARD;
        state_o = state_q;
    end
    always_ff @(posedge clk)
        if (reset) state_q <= F_IDLE;
        else state_q <= state_d;
endmodule

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: stall/flush controller for a 5-stage pipeline with inst/data bus tracking.
// Optional feature: PIPE_CTRL_PERF_EN adds four PERF_W-bit stall-cycle counters and their ports.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   id_load_use, ex_div_busy           ID load-use hazard, EX multicycle unit busy
//   mem_flush                          exception/eret commit pulse in MEM
//   if_req, if_addr_ok, if_data_ok     instruction bus handshake
//   mem_req, mem_addr_ok, mem_data_ok  data bus handshake
//   if_req_allow, if_discard           fetch may issue / drop returning inst data
//   pc_stall, seg_stall, seg_refresh   PC hold, segment hold and bubble ([0]=if_id..[3]=mem_wb)
//   perf_*_cnt                         winning-cause cycle counters (PIPE_CTRL_PERF_EN only)
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_load_use,
    input  logic       ex_div_busy,
    input  logic       mem_flush,
    input  logic       if_req,
    input  logic       if_addr_ok,
    input  logic       if_data_ok,
    input  logic       mem_req,
    input  logic       mem_addr_ok,
    input  logic       mem_data_ok,
    output logic       if_req_allow,
    output logic       if_discard,
    output logic       pc_stall,
    output logic [3:0] seg_stall,
    output logic [3:0] seg_refresh
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_dstall_cnt,
    output logic [PERF_W-1:0] perf_div_cnt,
    output logic [PERF_W-1:0] perf_lu_cnt,
    output logic [PERF_W-1:0] perf_istall_cnt
`endif
);
    logic [1:0] f_st, d_st;
    fetch_state_e f_state;
    data_state_e d_state;
    logic istall, dstall;
    cause_e cause;
    pipe_bus_track #(.DISCARD_EN(1'b1)) u_inst (
        .clk       (clk),
        .reset     (reset),
        .req_i     (if_req),
        .addr_ok_i (if_addr_ok),
        .data_ok_i (if_data_ok),
        .flush_i   (mem_flush),
        .state_o   (f_st),
        .stall_o   (istall)
    );
    pipe_bus_track #(.DISCARD_EN(1'b0)) u_data (
        .clk       (clk),
        .reset     (reset),
        .req_i     (mem_req),
        .addr_ok_i (mem_addr_ok),
        .data_ok_i (mem_data_ok),
        .flush_i   (1'b0),
        .state_o   (d_st),
        .stall_o   (dstall)
    );
    // Each stall cause bubbles the segment just past the held region, so the
    // held segments are exactly the ones below the refreshed bit.
    always_comb begin
        f_state = fetch_state_e'(f_st);
        d_state = data_state_e'(d_st);
        cause = mem_flush ? C_FLUSH : dstall ? C_DSTALL : ex_div_busy ? C_DIV :
                id_load_use ? C_LU : istall ? C_ISTALL : C_NONE;
        seg_refresh = (reset || cause == C_FLUSH) ? 4'b1111 :
                      cause == C_DSTALL ? seg_bit(SEG_MEM_WB) :
                      cause == C_DIV    ? seg_bit(SEG_EX_MEM) :
                      cause == C_LU     ? seg_bit(SEG_ID_EX) :
                      cause == C_ISTALL ? seg_bit(SEG_IF_ID) : 4'b0000;
        pc_stall = !reset && cause != C_NONE && cause != C_FLUSH;
        seg_stall = pc_stall ? seg_refresh - 4'd1 : 4'd0;
        if_req_allow = !reset && f_state == F_IDLE;
        // A flush in F_WAIT kills the fetch now, including data returning this very cycle.
        if_discard = !reset && (f_state == F_DISCARD || (mem_flush && f_state == F_WAIT));
    end
    assert property (@(posedge clk) disable iff (reset) !(mem_flush && d_state == D_WAIT));
`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] dstall_q, div_q, lu_q, istall_q;
    always_ff @(posedge clk)
        if (reset) begin
            dstall_q <= '0;
            div_q <= '0;
            lu_q <= '0;
            istall_q <= '0;
        end else begin
            dstall_q <= dstall_q + PERF_W'(cause == C_DSTALL);
            div_q <= div_q + PERF_W'(cause == C_DIV);
            lu_q <= lu_q + PERF_W'(cause == C_LU);
            istall_q <= istall_q + PERF_W'(cause == C_ISTALL);
        end
    assign perf_dstall_cnt = dstall_q;
    assign perf_div_cnt = div_q;
    assign perf_lu_cnt = lu_q;
    assign perf_istall_cnt = istall_q;
`endif
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: scoreboard bench for pipe_stage_ctrl hazard priority and bus tracking.
module tb_pipe_stage_ctrl;
    typedef struct packed {
        logic       pc;
        logic [3:0] st;
        logic [3:0] rf;
        logic       dis;
        logic       alw;
    } exp_t;
    localparam logic [9:0] LU = 10'd1, DV = 10'd2, FL = 10'd4, IR = 10'd8, IA = 10'd16,
                           ID = 10'd32, MR = 10'd64, MA = 10'd128, MD = 10'd256, RS = 10'd512;
    logic clk = 1'b0;
    logic reset, id_load_use, ex_div_busy, mem_flush, if_req, if_addr_ok, if_data_ok;
    logic mem_req, mem_addr_ok, mem_data_ok;
    logic if_req_allow, if_discard, pc_stall;
    logic [3:0] seg_stall, seg_refresh;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_dstall_cnt, perf_div_cnt, perf_lu_cnt, perf_istall_cnt;
`endif
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    pipe_stage_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_load_use  (id_load_use),
        .ex_div_busy  (ex_div_busy),
        .mem_flush    (mem_flush),
        .if_req       (if_req),
        .if_addr_ok   (if_addr_ok),
        .if_data_ok   (if_data_ok),
        .mem_req      (mem_req),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .if_req_allow (if_req_allow),
        .if_discard   (if_discard),
        .pc_stall     (pc_stall),
        .seg_stall    (seg_stall),
        .seg_refresh  (seg_refresh)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_dstall_cnt (perf_dstall_cnt),
        .perf_div_cnt    (perf_div_cnt),
        .perf_lu_cnt     (perf_lu_cnt),
        .perf_istall_cnt (perf_istall_cnt)
`endif
    );
    always #5 clk = ~clk;
    function automatic exp_t E(input logic pc, input logic [3:0] st, input logic [3:0] rf, input logic [1:0] da);
        return {pc, st, rf, da};
    endfunction
    function automatic exp_t obs();
        return {pc_stall, seg_stall, seg_refresh, if_discard, if_req_allow};
    endfunction
    task automatic drv(input logic [9:0] v);
        {reset, mem_data_ok, mem_addr_ok, mem_req, if_data_ok, if_addr_ok, if_req, mem_flush, ex_div_busy, id_load_use} = v;
    endtask
    task automatic test_reset();
        logic [9:0] s[2];
        exp_t x[2];
        exp_t e;
        s = '{RS | IR | IA | LU | FL, 10'd0};
        x = '{E(1'b0, 4'b0000, 4'b1111, 2'b00), E(1'b0, 4'b0000, 4'b0000, 2'b01)};
        foreach (s[i]) begin
            drv(s[i]);
            q.push_back(x[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL reset[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_load_use();
        logic [9:0] s[2];
        exp_t x[2];
        exp_t e;
        s = '{LU, 10'd0};
        x = '{E(1'b1, 4'b0001, 4'b0010, 2'b01), E(1'b0, 4'b0000, 4'b0000, 2'b01)};
        foreach (s[i]) begin
            drv(s[i]);
            q.push_back(x[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL load_use[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_div();
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            drv(i < 10 ? (DV | LU) : 10'd0);
            q.push_back(i < 10 ? E(1'b1, 4'b0011, 4'b0100, 2'b01) : E(1'b0, 4'b0000, 4'b0000, 2'b01));
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL div_busy[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_dstall();
        logic [9:0] s[6];
        exp_t x[6];
        exp_t e;
        s = '{MR, MR | MA, 10'd0, 10'd0, MD, 10'd0};
        x = '{E(1'b1, 4'b0111, 4'b1000, 2'b01), E(1'b0, 4'b0000, 4'b0000, 2'b01),
              E(1'b1, 4'b0111, 4'b1000, 2'b01), E(1'b1, 4'b0111, 4'b1000, 2'b01),
              E(1'b0, 4'b0000, 4'b0000, 2'b01), E(1'b0, 4'b0000, 4'b0000, 2'b01)};
        foreach (s[i]) begin
            drv(s[i]);
            q.push_back(x[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL dstall[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_istall();
        logic [9:0] s[5];
        exp_t x[5];
        exp_t e;
        s = '{IR, IR | IA, 10'd0, ID, 10'd0};
        x = '{E(1'b1, 4'b0000, 4'b0001, 2'b01), E(1'b0, 4'b0000, 4'b0000, 2'b01),
              E(1'b1, 4'b0000, 4'b0001, 2'b00), E(1'b0, 4'b0000, 4'b0000, 2'b00),
              E(1'b0, 4'b0000, 4'b0000, 2'b01)};
        foreach (s[i]) begin
            drv(s[i]);
            q.push_back(x[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL istall[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_fetch_flush();
        logic [9:0] s[6];
        exp_t x[6];
        exp_t e;
        s = '{IR | IA, FL, 10'd0, 10'd0, ID, 10'd0};
        x = '{E(1'b0, 4'b0000, 4'b0000, 2'b01), E(1'b0, 4'b0000, 4'b1111, 2'b10),
              E(1'b1, 4'b0000, 4'b0001, 2'b10), E(1'b1, 4'b0000, 4'b0001, 2'b10),
              E(1'b1, 4'b0000, 4'b0001, 2'b10), E(1'b0, 4'b0000, 4'b0000, 2'b01)};
        foreach (s[i]) begin
            drv(s[i]);
            q.push_back(x[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL fetch_flush[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_flush_data_ok();
        logic [9:0] s[3];
        exp_t x[3];
        exp_t e;
        s = '{IR | IA, FL | ID, 10'd0};
        x = '{E(1'b0, 4'b0000, 4'b0000, 2'b01), E(1'b0, 4'b0000, 4'b1111, 2'b10),
              E(1'b0, 4'b0000, 4'b0000, 2'b01)};
        foreach (s[i]) begin
            drv(s[i]);
            q.push_back(x[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL flush_data_ok[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_idle_flush();
        logic [9:0] s[4];
        exp_t x[4];
        exp_t e;
        s = '{IR | IA | FL, 10'd0, ID, 10'd0};
        x = '{E(1'b0, 4'b0000, 4'b1111, 2'b01), E(1'b1, 4'b0000, 4'b0001, 2'b10),
              E(1'b1, 4'b0000, 4'b0001, 2'b10), E(1'b0, 4'b0000, 4'b0000, 2'b01)};
        foreach (s[i]) begin
            drv(s[i]);
            q.push_back(x[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL idle_flush[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_priority();
        logic [9:0] s[6];
        exp_t x[6];
        exp_t e;
        s = '{FL | MR | DV | LU | IR, MR | DV | LU | IR, DV | LU | IR, LU | IR, IR, 10'd0};
        x = '{E(1'b0, 4'b0000, 4'b1111, 2'b01), E(1'b1, 4'b0111, 4'b1000, 2'b01),
              E(1'b1, 4'b0011, 4'b0100, 2'b01), E(1'b1, 4'b0001, 4'b0010, 2'b01),
              E(1'b1, 4'b0000, 4'b0001, 2'b01), E(1'b0, 4'b0000, 4'b0000, 2'b01)};
        foreach (s[i]) begin
            drv(s[i]);
            q.push_back(x[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL priority[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_reset_mid();
        logic [9:0] s[3];
        exp_t x[3];
        exp_t e;
        s = '{IR | IA | MR | MA, RS, 10'd0};
        x = '{E(1'b0, 4'b0000, 4'b0000, 2'b01), E(1'b0, 4'b0000, 4'b1111, 2'b00),
              E(1'b0, 4'b0000, 4'b0000, 2'b01)};
        foreach (s[i]) begin
            drv(s[i]);
            q.push_back(x[i]);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL reset_mid[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
    endtask
`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drv(i == 0 ? RS : i == 1 ? (MR | MA) : i < 7 ? DV : MD);
            q.push_back(i == 0 ? E(1'b0, 4'b0000, 4'b1111, 2'b00) :
                        (i == 1 || i == 7) ? E(1'b0, 4'b0000, 4'b0000, 2'b01) :
                        E(1'b1, 4'b0111, 4'b1000, 2'b01));
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL perf_seq[%0d] got %b want %b", i, obs(), e); end
            @(posedge clk); #1;
        end
        drv(10'd0);
        @(negedge clk);
        checks++;
        if (perf_dstall_cnt !== 32'd5) begin errors++; $display("FAIL perf_dstall got %0d want 5", perf_dstall_cnt); end
        checks++;
        if (perf_div_cnt !== 32'd0) begin errors++; $display("FAIL perf_div got %0d want 0", perf_div_cnt); end
        checks++;
        if (perf_lu_cnt !== 32'd0 || perf_istall_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_other got %0d/%0d want 0/0", perf_lu_cnt, perf_istall_cnt);
        end
        @(posedge clk); #1;
    endtask
`endif
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
    initial begin
        drv(RS);
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_div();
        test_dstall();
        test_istall();
        test_fetch_flush();
        test_flush_data_ok();
        test_idle_flush();
        test_priority();
        test_reset_mid();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
